// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: decodes DM vs. bridge-peripheral targets, checks alignment/range,
// drives DM byte enables and runs the peripheral req/ack handshake with a timeout.
module mem_access_ctrl #(
    parameter int unsigned DM_WORDS = 4096,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic [1:0]  mem_exc,
    output logic        dm_en,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        dev_req,
    output logic        dev_we,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic        dev_ack
);

    localparam int unsigned CW       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   rdata_q;
    logic          tmo_flag;

    logic is_word, is_half, is_byte;
    logic is_dev, in_dm, misalign, addr_err;
    logic start;
    logic [3:0] be_store;

    assign is_word = (mem_size == 2'b00) || (mem_size == 2'b11);
    assign is_half = (mem_size == 2'b01);
    assign is_byte = (mem_size == 2'b10);

    assign is_dev = (mem_addr == 32'h0000_7f00) || (mem_addr == 32'h0000_7f04) ||
                    (mem_addr == 32'h0000_7f08) || (mem_addr == 32'h0000_7f10) ||
                    (mem_addr == 32'h0000_7f14) || (mem_addr == 32'h0000_7f18);
    assign in_dm    = (mem_addr < DM_LIMIT);
    assign misalign = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    assign addr_err = misalign || (is_dev && !is_word) || (!is_dev && !in_dm);

    assign cnt_inc  = cnt + 1'b1;
    assign dm_addr  = {mem_addr[31:2], 2'b00};
    assign dev_req  = (state == S_REQ);
    assign mem_rdata = (state == S_DONE) ? rdata_q : dm_rdata;

    always_comb begin
        be_store = 4'b1111;
        dm_wdata = mem_wdata;
        if (is_byte) begin
            be_store = 4'b0001 << mem_addr[1:0];
            dm_wdata = {4{mem_wdata[7:0]}};
        end else if (is_half) begin
            be_store = 4'b0011 << {mem_addr[1], 1'b0};
            dm_wdata = {2{mem_wdata[15:0]}};
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        mem_exc    = 2'b00;
        dm_en      = 1'b0;
        dm_be      = 4'b0000;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    if (addr_err) begin
                        mem_exc = mem_we ? 2'b10 : 2'b01;
                    end else if (is_dev) begin
                        mem_stall  = 1'b1;
                        start      = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        dm_en = 1'b1;
                        dm_be = mem_we ? be_store : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                // ack takes priority over a timeout expiring in the same cycle
                if (dev_ack || (cnt_inc == CW'(TIMEOUT))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                mem_exc    = tmo_flag ? 2'b11 : 2'b00;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            tmo_flag  <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                dev_addr  <= mem_addr;
                dev_we    <= mem_we;
                dev_wdata <= mem_wdata;
                cnt       <= '0;
                tmo_flag  <= 1'b0;
            end
            if (state == S_REQ) begin
                cnt <= cnt_inc;
                if (dev_ack) begin
                    rdata_q <= dev_we ? '0 : dev_rdata;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    rdata_q  <= '0;
                    tmo_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single-cycle DM/error vectors plus
// hand-written device handshake, timeout, ack-vs-timeout and mid-access reset sequences.
module tb_mem_access_ctrl;

    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_exc;
    logic        dm_en;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dev_req, dev_we;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic        dev_ack;

    int n_vec = 0;
    int n_err = 0;

    mem_access_ctrl #(.DM_WORDS(4096), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_exc(mem_exc),
        .dm_en(dm_en), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [1:0]  exc;
        logic        en;
        logic [3:0]  be;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_req   = req;
        mem_we    = we;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_hi;
        logic done;

        //            req we  size   addr           wdata          rd             exc   en    be       ewd
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h0,         2'b00, 1'b0, 4'b0000, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0102, 32'h0000_00AB, 32'h0,         2'b00, 1'b1, 4'b0100, 32'hABABABAB};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0206, 32'h0000_1234, 32'h0,         2'b00, 1'b1, 4'b1100, 32'h12341234};
        vecs[3]  = '{1'b1, 1'b1, 2'b00, 32'h0000_3FFC, 32'hDEADBEEF, 32'h0,         2'b00, 1'b1, 4'b1111, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hCAFEF00D, 2'b00, 1'b1, 4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 32'h0000_3FFF, 32'h0,         32'h11223344, 2'b00, 1'b1, 4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0000_4000, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 2'b00, 32'h0000_4000, 32'h1,         32'h0,         2'b10, 1'b0, 4'b0000, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 32'h0000_7F0C, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0000, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 32'h0000_7F00, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0000, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 32'h0000_0002, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0000, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 32'h0000_0003, 32'h0,         32'h0,         2'b10, 1'b0, 4'b0000, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 32'h0000_7F04, 32'h0,         32'h0,         2'b10, 1'b0, 4'b0000, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 2'b11, 32'h0000_0008, 32'h89ABCDEF, 32'h0,         2'b00, 1'b1, 4'b1111, 32'h89ABCDEF};
        vecs[14] = '{1'b1, 1'b0, 2'b11, 32'h0000_0006, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0000, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 2'b10, 32'h0000_0003, 32'h0000_01FF, 32'h0,         2'b00, 1'b1, 4'b1000, 32'hFFFFFFFF};

        reset_n   = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        dm_rdata  = 32'h13579BDF;
        dev_rdata = 32'h0;
        dev_ack   = 1'b0;

        // Reset state
        #12;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_exc", 32'(mem_exc), 32'd0);
        chk("rst_dev_req", 32'(dev_req), 32'd0);
        chk("rst_dev_we", 32'(dev_we), 32'd0);
        chk("rst_dev_addr", dev_addr, 32'h0);
        chk("rst_dev_wdata", dev_wdata, 32'h0);
        chk("rst_dm_en", 32'(dm_en), 32'd0);
        chk("rst_rdata", mem_rdata, 32'h13579BDF);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        // Single-cycle DM and address-error vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            dm_rdata = vecs[i].rd;
            #2;
            chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
            chk($sformatf("v%0d_exc", i), 32'(mem_exc), 32'(vecs[i].exc));
            chk($sformatf("v%0d_dm_en", i), 32'(dm_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_dm_be", i), 32'(dm_be), 32'(vecs[i].be));
            chk($sformatf("v%0d_dev_req", i), 32'(dev_req), 32'd0);
            if (vecs[i].en) begin
                chk($sformatf("v%0d_dm_addr", i), dm_addr, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].rd);
                if (vecs[i].we)
                    chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].ewd);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        next_cycle();

        // lw 0x7f04, ack in cycle 3
        drive(1'b1, 1'b0, 2'b00, 32'h0000_7F04, 32'h0);
        #2;
        chk("A0_stall", 32'(mem_stall), 32'd1);
        chk("A0_dev_req", 32'(dev_req), 32'd0);
        chk("A0_dm_en", 32'(dm_en), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) begin
                dev_ack   = 1'b1;
                dev_rdata = 32'h12345678;
            end
            #2;
            chk($sformatf("A%0d_stall", c), 32'(mem_stall), 32'd1);
            chk($sformatf("A%0d_dev_req", c), 32'(dev_req), 32'd1);
        end
        chk("A_dev_addr", dev_addr, 32'h0000_7F04);
        chk("A_dev_we", 32'(dev_we), 32'd0);
        next_cycle();
        dev_ack   = 1'b0;
        dev_rdata = 32'h0;
        #2;
        chk("A4_stall", 32'(mem_stall), 32'd0);
        chk("A4_rdata", mem_rdata, 32'h12345678);
        chk("A4_exc", 32'(mem_exc), 32'd0);
        chk("A4_dev_req", 32'(dev_req), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        next_cycle();

        // sw 0x7f10 data 5, ack in cycle 2
        drive(1'b1, 1'b1, 2'b00, 32'h0000_7F10, 32'h5);
        next_cycle();
        #2;
        chk("B1_dev_req", 32'(dev_req), 32'd1);
        chk("B1_dev_we", 32'(dev_we), 32'd1);
        chk("B1_dev_wdata", dev_wdata, 32'h5);
        chk("B1_dev_addr", dev_addr, 32'h0000_7F10);
        next_cycle();
        dev_ack   = 1'b1;
        dev_rdata = 32'hFFFFFFFF;
        #2;
        chk("B2_stall", 32'(mem_stall), 32'd1);
        next_cycle();
        dev_ack = 1'b0;
        #2;
        chk("B3_stall", 32'(mem_stall), 32'd0);
        chk("B3_exc", 32'(mem_exc), 32'd0);
        chk("B3_rdata", mem_rdata, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        next_cycle();

        // lw 0x7f08 with no ack: timeout
        drive(1'b1, 1'b0, 2'b00, 32'h0000_7F08, 32'h0);
        dm_rdata = 32'hFFFF0000;
        n_hi = 0;
        done = 1'b0;
        for (int c = 1; c <= int'(TMO) + 5 && !done; c++) begin
            next_cycle();
            #2;
            if (dev_req) n_hi++;
            if (!mem_stall) begin
                done = 1'b1;
                chk("C_done_cycle", 32'(c), 32'(TMO + 1));
                chk("C_exc", 32'(mem_exc), 32'd3);
                chk("C_rdata", mem_rdata, 32'h0);
            end
        end
        chk("C_finished", 32'(done), 32'd1);
        chk("C_req_cycles", 32'(n_hi), 32'(TMO));
        next_cycle();
        drive(1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0);
        dm_rdata = 32'h55;
        dev_ack  = 1'b1;
        #2;
        chk("C_next_stall", 32'(mem_stall), 32'd0);
        chk("C_next_exc", 32'(mem_exc), 32'd0);
        chk("C_next_rdata", mem_rdata, 32'h55);
        chk("C_next_dm_en", 32'(dm_en), 32'd1);
        next_cycle();
        dev_ack = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("C_ack_ignored_stall", 32'(mem_stall), 32'd0);
        chk("C_ack_ignored_req", 32'(dev_req), 32'd0);
        next_cycle();

        // ack in the very cycle the counter reaches TIMEOUT: ack wins
        drive(1'b1, 1'b0, 2'b00, 32'h0000_7F14, 32'h0);
        for (int c = 1; c <= int'(TMO); c++) begin
            next_cycle();
            if (c == int'(TMO)) begin
                dev_ack   = 1'b1;
                dev_rdata = 32'hA5A5A5A5;
            end
        end
        #2;
        chk("D_last_req", 32'(dev_req), 32'd1);
        next_cycle();
        dev_ack   = 1'b0;
        dev_rdata = 32'h0;
        #2;
        chk("D_stall", 32'(mem_stall), 32'd0);
        chk("D_exc", 32'(mem_exc), 32'd0);
        chk("D_rdata", mem_rdata, 32'hA5A5A5A5);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        next_cycle();

        // reset pulsed during REQ
        drive(1'b1, 1'b0, 2'b00, 32'h0000_7F18, 32'h0);
        next_cycle();
        #2;
        chk("F_req_before", 32'(dev_req), 32'd1);
        #1;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("F_req_async", 32'(dev_req), 32'd0);
        chk("F_stall", 32'(mem_stall), 32'd0);
        chk("F_dev_addr", dev_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 2'b00, 32'h0000_7F00, 32'h0);
        #2;
        chk("F0_stall", 32'(mem_stall), 32'd1);
        next_cycle();
        dev_ack   = 1'b1;
        dev_rdata = 32'h0BADC0DE;
        #2;
        chk("F1_dev_req", 32'(dev_req), 32'd1);
        chk("F1_dev_addr", dev_addr, 32'h0000_7F00);
        next_cycle();
        dev_ack   = 1'b0;
        dev_rdata = 32'h0;
        #2;
        chk("F2_stall", 32'(mem_stall), 32'd0);
        chk("F2_rdata", mem_rdata, 32'h0BADC0DE);
        chk("F2_exc", 32'(mem_exc), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the CPU MEM stage and the two data targets: the data memory (single-cycle) and the bridge peripherals (Timer0/Timer1 registers, multi-cycle req/ack). It decodes the address, checks alignment and range, drives DM byte enables, and runs the peripheral handshake with a timeout. It stalls the pipeline while a peripheral access is outstanding, then hands the raw 32-bit word to the load-extension unit.

## Interface
- DM_WORDS, 4096: DM size in words; DM window is 0 .. DM_WORDS*4-1
- TIMEOUT, 15: cycles in REQ without dev_ack before a bus-error abort
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- mem_req  in  1  MEM stage holds a valid load/store
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 word, 01 half, 10 byte (11 treated as word)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-aligned
- mem_stall  out  1  freeze pipeline
- mem_rdata  out  32  raw aligned word to extension unit
- mem_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout
- dm_en  out  1  DM access this cycle
- dm_be  out  4  DM byte write enables
- dm_addr  out  32  word-aligned DM address (mem_addr with [1:0]=0)
- dm_wdata  out  32  store data replicated to lanes (byte x4, half x2)
- dm_rdata  in  32  DM combinational read word
- dev_req, dev_we  out  1  peripheral request / write
- dev_addr, dev_wdata  out  32  registered peripheral address / data
- dev_rdata  in  32  peripheral read data, valid with dev_ack
- dev_ack  in  1  peripheral completion, one cycle

## Operation
- Device addresses: exactly 0x7f00, 0x7f04, 0x7f08, 0x7f10, 0x7f14, 0x7f18. Device accesses must be word size.
- Address error (combinational, same cycle as mem_req): half with addr[0]=1, word with addr[1:0]!=0, device address with size!=word, or address neither in DM window nor a device address. Load -> 01, store -> 10. No DM or device access, no stall.
- DM path (legal, in window): dm_en=1; store: dm_be = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word); load: dm_be=0000. mem_rdata=dm_rdata, mem_stall=0. FSM stays IDLE.
- Device path: FSM IDLE -> REQ -> DONE -> IDLE.
  - IDLE: legal device access -> mem_stall=1, register dev_addr/dev_we/dev_wdata, clear counter, go REQ.
  - REQ: dev_req=1, mem_stall=1, counter++ each cycle. dev_ack=1 -> latch dev_rdata (loads; 0 for stores), go DONE. Counter==TIMEOUT without ack -> rdata latch 0, exc flag set, go DONE.
  - DONE: dev_req=0, mem_stall=0, mem_rdata=latched word, mem_exc=11 if timed out else 00; go IDLE. The mem_req present in DONE is the completing instruction and is not restarted.
- dev_ack outside REQ ignored. mem_* inputs must be held stable while mem_stall=1.
- mem_exc asserts only for one cycle per instruction; dm_en=0 whenever mem_req=0.

## Timing
- Reset values: FSM IDLE, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, latch=0, counter=0, timeout flag=0; hence mem_stall=0, mem_exc=00, mem_rdata=dm_rdata path, dm_en=0 with mem_req=0.
- Reset asserted mid-access: dev_req falls asynchronously, FSM to IDLE, access abandoned.
- DM access: 0 added cycles.
- Device access: mem_req in cycle 0 (stall=1), dev_req from cycle 1; ack in cycle k>=1 -> DONE at k+1; stall cycles = k+1 (minimum 2).
- Timeout: with no ack, REQ lasts TIMEOUT cycles (dev_req high cycles 1..TIMEOUT), DONE at TIMEOUT+1 with exc=11.
- Ack arriving in the same cycle the counter hits TIMEOUT: ack wins, no exception.

## Test plan
- sb 0xAB to 0x0000_0102 -> dm_en=1, dm_be=0100, dm_wdata=0xABABABAB, stall=0, exc=00.
- lw 0x7f04, dev_ack in cycle 3 with dev_rdata=0x1234_5678 -> stall cycles 0-3, DONE cycle 4 mem_rdata=0x12345678, stall=0.
- sw 0x7f10, data 0x5 -> dev_req cycles 1.., dev_we=1, dev_wdata=5, dev_addr=0x7f10; after ack, DONE with exc=00.
- lw 0x7f0c, lh 0x7f00, lw 0x0000_0002, sh 0x0000_0003 -> exc 01,01,01,10 same cycle, no dm_en, no dev_req, stall=0.
- lw 0x7f08 with dev_ack never asserted -> dev_req high 15 cycles, then exc=11, mem_rdata=0, stall drops; next DM lw proceeds with no stall.
- reset_n pulsed low during REQ -> dev_req=0 immediately, stall=0, following lw 0x7f00 runs full handshake normally.
